// File: rtl/keyboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_decoder
//  Description : PS/2 keyboard receiver. Synchronizes the PS/2 pins, frames
//                11-bit PS/2 words, and decodes the scancode stream for the
//                Up, Space, Down and Enter keys into one-cycle press pulses
//                and held-key levels.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyboard_decoder #(
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keyboard_out,
  output logic [3:0] key_held,
  output logic       frame_error
);

  // Timeout counter is at least 13 bits wide, wider if the limit needs it.
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
  localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] c_TO_ONE   = TO_W'(1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_DATA   = 2'd1;
  localparam logic [1:0] c_ST_PARITY = 2'd2;
  localparam logic [1:0] c_ST_STOP   = 2'd3;

  localparam logic [7:0] c_SC_EXT   = 8'hE0;
  localparam logic [7:0] c_SC_BRK   = 8'hF0;
  localparam logic [7:0] c_SC_UP    = 8'h75;
  localparam logic [7:0] c_SC_SPACE = 8'h29;
  localparam logic [7:0] c_SC_DOWN  = 8'h72;
  localparam logic [7:0] c_SC_ENTER = 8'h5A;

  logic            r_clk_meta, r_clk_sync, r_clk_prev;
  logic            r_dat_meta, r_dat_sync;
  logic [1:0]      r_state, w_state_nx;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par_err;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_byte_valid, w_byte_valid_nx;
  logic            r_frame_err, w_frame_err_nx;
  logic [7:0]      r_byte;
  logic            r_ext, r_brk;
  logic [3:0]      r_key_out, r_key_held;
  logic            w_fall, w_timeout, w_edge;
  logic [3:0]      w_hit;

  // Two-flop synchronizers; idle-high reset so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  // A timeout wins over an edge arriving in the same cycle.
  assign w_timeout = (r_state != c_ST_IDLE) && (r_to_cnt == c_TO_LIMIT);
  assign w_edge    = w_fall & ~w_timeout;

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Frame FSM next-state logic.
  always_comb begin
    w_state_nx = r_state;
    if (w_timeout) begin
      w_state_nx = c_ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        c_ST_IDLE:   if (!r_dat_sync) w_state_nx = c_ST_DATA;
        c_ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nx = c_ST_PARITY;
        c_ST_PARITY: w_state_nx = c_ST_STOP;
        c_ST_STOP:   w_state_nx = c_ST_IDLE;
        default:     w_state_nx = c_ST_IDLE;
      endcase
    end
  end

  // Frame FSM outputs: byte accept on a clean stop, error on bad start/parity/stop or timeout.
  always_comb begin
    w_byte_valid_nx = 1'b0;
    w_frame_err_nx  = 1'b0;
    if (w_timeout) begin
      w_frame_err_nx = 1'b1;
    end else if (w_fall) begin
      if (r_state == c_ST_IDLE && r_dat_sync) begin
        w_frame_err_nx = 1'b1;
      end else if (r_state == c_ST_STOP) begin
        if (r_dat_sync && !r_par_err) w_byte_valid_nx = 1'b1;
        else                          w_frame_err_nx  = 1'b1;
      end
    end
  end

  // Frame datapath: shift register, bit counter, parity flag, inactivity counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_par_err    <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte       <= 8'd0;
    end else begin
      if (r_state == c_ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                             r_to_cnt <= r_to_cnt + c_TO_ONE;

      if (w_edge) begin
        case (r_state)
          c_ST_IDLE: begin
            r_bit_cnt <= 3'd0;
            r_par_err <= 1'b0;
          end
          c_ST_DATA: begin
            r_shift   <= {r_dat_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          // Odd parity: data plus parity bit must XOR to 1.
          c_ST_PARITY: r_par_err <= ~(^{r_dat_sync, r_shift});
          default: ;
        endcase
      end

      r_byte_valid <= w_byte_valid_nx;
      r_frame_err  <= w_frame_err_nx;
      if (w_byte_valid_nx) r_byte <= r_shift;
    end
  end

  // Key lookup on {ext, code}; the four codes are distinct so at most one bit is set.
  assign w_hit[3] =  r_ext && (r_byte == c_SC_UP);
  assign w_hit[2] = !r_ext && (r_byte == c_SC_SPACE);
  assign w_hit[1] =  r_ext && (r_byte == c_SC_DOWN);
  assign w_hit[0] = !r_ext && (r_byte == c_SC_ENTER);

  // Scancode layer: prefix tracking, make/break handling, typematic suppression.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_key_out  <= 4'd0;
      r_key_held <= 4'd0;
    end else begin
      r_key_out <= 4'd0;
      if (r_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_valid) begin
        if (r_byte == c_SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_byte == c_SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          if (r_brk) begin
            r_key_held <= r_key_held & ~w_hit;
          end else begin
            r_key_out  <= w_hit & ~r_key_held;
            r_key_held <= r_key_held | w_hit;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign keyboard_out = r_key_out;
  assign key_held     = r_key_held;
  assign frame_error  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keyboard_decoder
//  Description : Directed self-checking bench for keyboard_decoder. Drives
//                PS/2 frames bit by bit and checks pulses, held levels,
//                error pulses and their cycle timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_decoder;

  localparam int TO   = 200;  // TIMEOUT_CYCLES used for this bench
  localparam int HALF = 20;   // half PS/2 clock period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keyboard_out;
  logic [3:0] key_held;
  logic       frame_error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int n_multi = 0;
  int n_err   = 0;
  int last_cyc = 0;
  int err_cyc  = 0;
  int fall_cyc = 0;
  logic [3:0] last_out = 4'd0;

  keyboard_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .keyboard_out (keyboard_out),
    .key_held     (key_held),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (keyboard_out !== 4'd0 && !rst) begin
      n_pulse  = n_pulse + 1;
      last_out = keyboard_out;
      last_cyc = cyc;
      if ($countones(keyboard_out) > 1) n_multi = n_multi + 1;
    end
    if (frame_error === 1'b1) begin
      n_err   = n_err + 1;
      err_cyc = cyc;
    end
  end

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    logic par;
    par = ~(^b) ^ flip;
    send_bits({1'b1, par, b, 1'b0}, 11);
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (keyboard_out !== 4'd0) begin n_fail++; $display("FAIL reset_out: got %b want 0000", keyboard_out); end
    n_tests++; if (key_held !== 4'd0) begin n_fail++; $display("FAIL reset_held: got %b want 0000", key_held); end
    n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_error); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enter();
    int p0, e0;
    p0 = n_pulse; e0 = n_err;
    send_frame(8'h5A, 1'b0);
    n_tests++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL enter_pulses: got %0d want 1", n_pulse - p0); end
    n_tests++; if (last_out !== 4'b0001) begin n_fail++; $display("FAIL enter_out: got %b want 0001", last_out); end
    n_tests++; if (last_cyc - fall_cyc != 4) begin n_fail++; $display("FAIL enter_latency: got %0d want 4", last_cyc - fall_cyc); end
    n_tests++; if (key_held !== 4'b0001) begin n_fail++; $display("FAIL enter_held: got %b want 0001", key_held); end
    n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL enter_err: got %0d want %0d", n_err, e0); end
  endtask

  task automatic test_up_repeat();
    int p0;
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
    end
    n_tests++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL up_rep_pulses: got %0d want 1", n_pulse - p0); end
    n_tests++; if (last_out !== 4'b1000) begin n_fail++; $display("FAIL up_rep_out: got %b want 1000", last_out); end
    n_tests++; if (key_held !== 4'b1001) begin n_fail++; $display("FAIL up_rep_held: got %b want 1001", key_held); end
  endtask

  task automatic test_up_break();
    int p0;
    p0 = n_pulse;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    n_tests++; if (n_pulse != p0) begin n_fail++; $display("FAIL up_brk_pulses: got %0d want 0", n_pulse - p0); end
    n_tests++; if (key_held !== 4'b0001) begin n_fail++; $display("FAIL up_brk_held: got %b want 0001", key_held); end
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    n_tests++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL up_remake_pulses: got %0d want 1", n_pulse - p0); end
    n_tests++; if (last_out !== 4'b1000) begin n_fail++; $display("FAIL up_remake_out: got %b want 1000", last_out); end
  endtask

  task automatic test_bad_parity();
    int p0, e0;
    p0 = n_pulse; e0 = n_err;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b1);
    n_tests++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL parity_err: got %0d want 1", n_err - e0); end
    // The error flushed the E0 prefix, so a bare 72 is unmapped.
    send_frame(8'h72, 1'b0);
    n_tests++; if (n_pulse != p0) begin n_fail++; $display("FAIL parity_pulses: got %0d want 0", n_pulse - p0); end
    send_frame(8'h29, 1'b0);
    n_tests++; if (last_out !== 4'b0100 || n_pulse - p0 != 1) begin n_fail++; $display("FAIL parity_recover: got %b/%0d want 0100/1", last_out, n_pulse - p0); end
    n_tests++; if (key_held !== 4'b1101) begin n_fail++; $display("FAIL parity_held: got %b want 1101", key_held); end
  endtask

  task automatic test_timeout();
    int p0, e0;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    n_tests++; if (key_held !== 4'b1100) begin n_fail++; $display("FAIL enter_brk_held: got %b want 1100", key_held); end
    p0 = n_pulse; e0 = n_err;
    send_bits({3'b000, 8'h0F, 1'b0}, 5);
    repeat (TO + 20) @(negedge clk);
    n_tests++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", n_err - e0); end
    n_tests++; if (err_cyc - fall_cyc != TO + 4) begin n_fail++; $display("FAIL timeout_time: got %0d want %0d", err_cyc - fall_cyc, TO + 4); end
    send_frame(8'h5A, 1'b0);
    n_tests++; if (last_out !== 4'b0001 || n_pulse - p0 != 1) begin n_fail++; $display("FAIL timeout_recover: got %b/%0d want 0001/1", last_out, n_pulse - p0); end
  endtask

  task automatic test_unmapped();
    int p0;
    p0 = n_pulse;
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hAA, 1'b0);
    send_frame(8'h72, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    n_tests++; if (n_pulse != p0) begin n_fail++; $display("FAIL unmapped_pulses: got %0d want 0", n_pulse - p0); end
    n_tests++; if (key_held !== 4'b1001) begin n_fail++; $display("FAIL unmapped_held: got %b want 1001", key_held); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = n_pulse;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    n_tests++; if (last_out !== 4'b0010) begin n_fail++; $display("FAIL b2b_down: got %b want 0010", last_out); end
    send_frame(8'h29, 1'b0);
    n_tests++; if (n_pulse - p0 != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", n_pulse - p0); end
    n_tests++; if (key_held !== 4'b1111) begin n_fail++; $display("FAIL b2b_held: got %b want 1111", key_held); end
  endtask

  task automatic test_reset_midframe();
    int p0, e0;
    e0 = n_err;
    send_bits({3'b000, 8'h5A, 1'b0}, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (TO + 20) @(negedge clk);
    n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL midrst_err: got %0d want 0", n_err - e0); end
    n_tests++; if (key_held !== 4'b0000) begin n_fail++; $display("FAIL midrst_held: got %b want 0000", key_held); end
    p0 = n_pulse;
    send_frame(8'h5A, 1'b0);
    n_tests++; if (last_out !== 4'b0001 || n_pulse - p0 != 1) begin n_fail++; $display("FAIL midrst_make: got %b/%0d want 0001/1", last_out, n_pulse - p0); end
  endtask

  initial begin
    test_reset();
    test_enter();
    test_up_repeat();
    test_up_break();
    test_bad_parity();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_reset_midframe();
    n_tests++; if (n_multi != 0) begin n_fail++; $display("FAIL onehot: got %0d multi-bit cycles want 0", n_multi); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyboard_decoder.md
# keyboard_decoder

Receives PS/2 keyboard frames and turns the scancode stream for the game's keys into clean, single-cycle key-press pulses on `keyboard_out[3:0]`. `keyboard_out[3:0]` drives the `keyboard_in[3:0]` input of the menu state machine and the in-game control logic. It also provides held-key levels for gameplay. It sits between the board's PS/2 pins and all key consumers.

## Interface
- `TIMEOUT_CYCLES`, default 6500: idle `clk` cycles inside a frame before the frame is abandoned (100 µs at 65 MHz).
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  reset; synchronous, active-high.
- `ps2_clk`  input  1  PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  input  1  PS/2 data pin, asynchronous to `clk`.
- `keyboard_out`  output  4  one-cycle press pulses: [3] Up (E0 75), [2] Space (29), [1] Down (E0 72), [0] Enter (5A).
- `key_held`  output  4  level per key, same bit mapping: high from make until break.
- `frame_error`  output  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- **Input sync and edge detect**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - A falling edge is the cycle where the synced `ps2_clk` is 0 and its previous value was 1. `ps2_data` is sampled only on falling edges.
- **Frame FSM:** IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on a falling edge with data 0 (start bit), go to DATA and clear the bit counter. A start sample of 1 stays in IDLE and pulses `frame_error`.
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter. After bit 7, go to PARITY.
  - PARITY: check odd parity. The 8 data bits plus the parity bit must contain an odd number of 1s. On a mismatch, latch an error flag.
  - STOP: the stop bit must be 1.
    - If the stop bit is 1 and there is no parity error, raise `byte_valid` for one cycle with the byte.
    - Otherwise pulse `frame_error` and discard the byte.
  - Every path from STOP returns to IDLE.
  - Timeout: a 13-bit (minimum) counter runs while not in IDLE and clears on every falling edge. When it reaches `TIMEOUT_CYCLES`, return to IDLE, pulse `frame_error`, and emit no byte.
- **Scancode layer:** two flags, `ext` and `brk`.
  - Byte E0 sets `ext`. Byte F0 sets `brk`. Neither prefix produces any output.
  - Any other byte is looked up as {`ext`, code}. Only the four mappings listed in the Interface match.
    - On a match with `brk` = 0: if the matching `key_held` bit is 0, pulse that `keyboard_out` bit and set `key_held`. If the bit is already 1 (typematic repeat), produce no pulse.
    - On a match with `brk` = 1: clear that `key_held` bit and produce no pulse.
    - A non-match (e.g. 75 without E0, AA, FA) produces no output and no state change.
  - After any non-prefix byte, clear both `ext` and `brk`.
  - A `frame_error` also clears `ext` and `brk`.
- At most one `keyboard_out` bit is high in any cycle.

## Timing
- **Reset:** `keyboard_out` = 0, `key_held` = 0, `frame_error` = 0. FSM in IDLE, counters 0, `ext` = `brk` = 0.
  - `rst` mid-frame abandons the frame with no `frame_error`.
  - Held keys are forgotten; the next make of a key pulses again.
- **Pin-to-edge latency:** a `ps2_clk` falling transition is detected 2–3 `clk` cycles after the pin change.
- **Stop-bit to pulse:** `byte_valid` is asserted the cycle after the stop-bit edge is detected. `keyboard_out` and the `key_held` update appear the cycle after that, for exactly 1 cycle.
- **Error timing:** `frame_error` is asserted the cycle after the offending edge is detected, or the cycle after the timeout is reached.
- **Back-to-back frames:** frames with minimum inter-frame gap (one idle PS/2 clock period) decode without loss.
- **Simultaneous events:** a falling edge arriving in the same cycle the timeout is reached is treated as a timeout. The edge is ignored; if it is a start bit, the device resends.
- **Consumers:** each press yields exactly one pulse, so consumers need no edge detection.

## Test plan
- **Enter make:** frame 5A (start 0, bits LSB first, parity 1, stop 1), PS/2 clock period 60 µs.
  - `keyboard_out` = 0001 for 1 cycle, 2 cycles after the stop edge.
  - `key_held[0]` = 1, `frame_error` stays 0.
- **Up with repeat:** frames E0 75, E0 75, E0 75.
  - Exactly one pulse, `keyboard_out` = 1000.
  - `key_held[3]` stays 1.
- **Up break:** then E0 F0 75.
  - `key_held[3]` → 0, no pulse.
  - A subsequent E0 75 pulses 1000 again.
- **Bad parity, then recovery:** frame 72 with parity flipped.
  - `frame_error` pulses once, no `keyboard_out`.
  - A following valid 29 gives 0100.
- **Timeout:** send start bit plus 4 data bits, then hold `ps2_clk` high.
  - `frame_error` pulses after `TIMEOUT_CYCLES`.
  - A following valid 5A decodes to 0001.
- **Unmapped and prefix-flush cases:** send 75 without E0, then E0 AA, then F0 29.
  - No pulses.
  - `key_held` unchanged except bit 2 cleared, if it was set before the sequence.
